// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MEM pipeline stage.
// Holds bus widths, stall-vector positions, access-size codes, FSM state
// encodings and the packed layout of the EX->MEM bus.
package mem_stage_pkg;

   localparam int unsigned EX_TO_MEM_WD = 107;
   localparam int unsigned MEM_TO_WB_WD = 70;
   localparam int unsigned MEM_TO_ID_WD = 38;
   localparam int unsigned LOHI_WD      = 65;
   localparam int unsigned STALL_WD     = 6;

   // Positions in the stall vector
   localparam int unsigned STALL_MEM_IN = 3;
   localparam int unsigned STALL_WB_IN  = 4;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   typedef enum logic [1:0] {
      SizeByte = 2'd0,
      SizeHalf = 2'd1,
      SizeWord = 2'd2
   } mem_size_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2,
      StDone = 2'd3
   } mem_state_e;

   // Field order matches the EX->MEM bus, MSB first
   typedef struct packed {
      logic [31:0] pc;
      logic        mem_en;
      logic        mem_we;
      mem_size_e   mem_size;
      logic        mem_sign;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
      logic [31:0] store_data;
   } ex_to_mem_t;

   typedef struct packed {
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
   } rf_wr_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response channel between the MEM stage and memory.
//   data_req/data_wr/data_size/data_addr/data_wdata : request, stage -> memory
//   data_addr_ok : request accepted
//   data_data_ok : read data valid or write complete
//   data_rdata   : read data
// master = MEM stage side, slave = memory side.
interface mem_stage_if;

   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );

endinterface

// File: rtl/mem_align.sv
// Combinational load-lane extraction and store-lane replication.
//   size_i, sign_i, addr_i : access size, sign-extend enable, low address bits
//   rdata_i                : raw 32-bit read word
//   store_data_i           : unaligned store operand
//   load_data_o            : extracted, extended load result
//   wdata_o                : lane-replicated store data
module mem_align
   import mem_stage_pkg::*;
(
   input  mem_size_e   size_i,
   input  logic        sign_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] load_data_o,
   output logic [31:0] wdata_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      load_data_o = rdata_i;
      wdata_o     = store_data_i;
      byte_lane   = rdata_i[{addr_i, 3'b000} +: 8];
      half_lane   = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (size_i)
         SizeByte: begin
            load_data_o = {{24{sign_i & byte_lane[7]}}, byte_lane};
            wdata_o     = {4{store_data_i[7:0]}};
         end
         SizeHalf: begin
            load_data_o = {{16{sign_i & half_lane[15]}}, half_lane};
            wdata_o     = {2{store_data_i[15:0]}};
         end
         default: begin
            load_data_o = rdata_i;
            wdata_o     = store_data_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: input register, one-request-per-instruction memory
// FSM, read-data hold register and write-back/forwarding bus assembly.
//   clk, rst            : clock, asynchronous active-low reset
//   stall               : pipeline stall vector (bit 3 this stage, bit 4 WB)
//   ex_to_mem_bus       : instruction bundle from EX
//   ex_mem_lohi_bus     : HI/LO write bundle from EX, registered through
//   data_if             : memory request/response channel (master)
//   stallreq_for_mem    : stall request while a memory access is outstanding
//   mem_to_wb_bus       : {pc, rf_we, rf_waddr, rf_wdata}
//   mem_to_id_bus       : {rf_we, rf_waddr, rf_wdata} for forwarding
//   mem_wb_lohi_bus     : registered HI/LO bundle
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STALL_WD-1:0]     stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [LOHI_WD-1:0]      ex_mem_lohi_bus,
   mem_stage_if.master             data_if,
   output logic                    stallreq_for_mem,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
   output logic [LOHI_WD-1:0]      mem_wb_lohi_bus
);

   ex_to_mem_t           ex_in;
   ex_to_mem_t           ex_q, ex_d;
   logic [LOHI_WD-1:0]   lohi_q, lohi_d;
   mem_state_e           state_q, state_d;
   logic [31:0]          rdata_hold_q, rdata_hold_d;
   logic                 load_new, load_bubble;
   logic                 is_load, is_store;
   logic [31:0]          load_data, store_wdata;
   rf_wr_t               rf_wr;

   assign ex_in       = ex_to_mem_t'(ex_to_mem_bus);
   assign load_new    = (stall[STALL_MEM_IN] == NO_STOP);
   assign load_bubble = (stall[STALL_MEM_IN] == STOP) && (stall[STALL_WB_IN] == NO_STOP);

   // Input register
   always_comb begin
      ex_d   = ex_q;
      lohi_d = lohi_q;
      if (load_bubble) begin
         ex_d   = '0;
         lohi_d = '0;
      end else if (load_new) begin
         ex_d   = ex_in;
         lohi_d = ex_mem_lohi_bus;
      end
   end

   // Memory FSM. The request is raised from the edge that loads the
   // instruction, so a held stage never re-enters StReq for the same one.
   always_comb begin
      state_d      = state_q;
      rdata_hold_d = rdata_hold_q;
      unique case (state_q)
         StIdle: begin
            if (load_new && ex_in.mem_en) state_d = StReq;
         end
         StReq: begin
            if (data_if.data_addr_ok) begin
               state_d = data_if.data_data_ok ? StDone : StWait;
            end
         end
         StWait: begin
            if (data_if.data_data_ok) state_d = StDone;
         end
         StDone: begin
            if (load_new) begin
               state_d = ex_in.mem_en ? StReq : StIdle;
            end else if (load_bubble) begin
               // Finished access moved on to WB and a bubble replaced it
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if ((state_d == StDone) && (state_q != StDone)) begin
         rdata_hold_d = data_if.data_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q         <= '0;
         lohi_q       <= '0;
         state_q      <= StIdle;
         rdata_hold_q <= '0;
      end else begin
         ex_q         <= ex_d;
         lohi_q       <= lohi_d;
         state_q      <= state_d;
         rdata_hold_q <= rdata_hold_d;
      end
   end

   mem_align u_mem_align (
      .size_i       (ex_q.mem_size),
      .sign_i       (ex_q.mem_sign),
      .addr_i       (ex_q.ex_result[1:0]),
      .rdata_i      (rdata_hold_q),
      .store_data_i (ex_q.store_data),
      .load_data_o  (load_data),
      .wdata_o      (store_wdata)
   );

   assign is_load  = ex_q.mem_en & ~ex_q.mem_we;
   assign is_store = ex_q.mem_en & ex_q.mem_we;

   always_comb begin
      rf_wr.rf_we    = ex_q.rf_we & ~is_store;
      rf_wr.rf_waddr = ex_q.rf_waddr;
      rf_wr.rf_wdata = is_load ? load_data : ex_q.ex_result;
   end

   assign data_if.data_req   = (state_q == StReq);
   assign data_if.data_wr    = ex_q.mem_we;
   assign data_if.data_size  = ex_q.mem_size;
   assign data_if.data_addr  = ex_q.ex_result;
   assign data_if.data_wdata = store_wdata;

   assign stallreq_for_mem = ex_q.mem_en && (state_q != StDone);
   assign mem_to_wb_bus    = {ex_q.pc, rf_wr};
   assign mem_to_id_bus    = rf_wr;
   assign mem_wb_lohi_bus  = lohi_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam logic [5:0] STALL_RUN    = 6'b000000;
   localparam logic [5:0] STALL_HOLD   = 6'b011111;
   localparam logic [5:0] STALL_BUBBLE = 6'b001111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [5:0]    stall = STALL_RUN;
   logic [106:0]  ex_bus = '0;
   logic [64:0]   lohi_in = '0;
   logic          stallreq;
   logic [69:0]   wb_bus;
   logic [37:0]   id_bus;
   logic [64:0]   lohi_out;

   int n_cmp = 0;
   int n_bad = 0;

   mem_stage_if bus_if ();

   mem_stage dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .ex_to_mem_bus    (ex_bus),
      .ex_mem_lohi_bus  (lohi_in),
      .data_if          (bus_if),
      .stallreq_for_mem (stallreq),
      .mem_to_wb_bus    (wb_bus),
      .mem_to_id_bus    (id_bus),
      .mem_wb_lohi_bus  (lohi_out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [106:0] mk_ex(input logic [31:0] pc, input logic en, input logic we,
                                          input logic [1:0] size, input logic sign,
                                          input logic rfwe, input logic [4:0] waddr,
                                          input logic [31:0] res, input logic [31:0] sd);
      return {pc, en, we, size, sign, rfwe, waddr, res, sd};
   endfunction

   task automatic respond(input logic aok, input logic dok, input logic [31:0] rd);
      bus_if.data_addr_ok = aok;
      bus_if.data_data_ok = dok;
      bus_if.data_rdata   = rd;
   endtask

   // Load with an immediate accept+data response, then retire it
   task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic sign, input logic [31:0] rd, input logic [31:0] exp);
      ex_bus = mk_ex(32'h4000, 1'b1, 1'b0, size, sign, 1'b1, 5'd9, addr, 32'h0);
      stall  = STALL_RUN;
      tick();
      check_eq({tag, "_req"}, bus_if.data_req, 1'b1);
      ex_bus = '0;
      stall  = STALL_HOLD;
      respond(1'b1, 1'b1, rd);
      tick();
      respond(1'b0, 1'b0, 32'h0BAD_F00D);
      #1;
      check_eq({tag, "_id"}, id_bus, {1'b1, 5'd9, exp});
      stall = STALL_RUN;
      tick();
   endtask

   task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] sd,
                           input logic [31:0] exp_wdata);
      ex_bus = mk_ex(32'h5000, 1'b1, 1'b1, size, 1'b0, 1'b1, 5'd4, 32'h2, sd);
      stall  = STALL_RUN;
      tick();
      check_eq({tag, "_wdata"}, bus_if.data_wdata, exp_wdata);
      check_eq({tag, "_ctl"}, {bus_if.data_req, bus_if.data_wr, bus_if.data_size},
               {1'b1, 1'b1, size});
      check_eq({tag, "_rfwe"}, wb_bus[37], 1'b0);
      ex_bus = '0;
      stall  = STALL_HOLD;
      respond(1'b1, 1'b1, 32'h0);
      tick();
      respond(1'b0, 1'b0, 32'h0BAD_F00D);
      stall = STALL_RUN;
      tick();
   endtask

   initial begin
      respond(1'b0, 1'b0, 32'h0BAD_F00D);
      // Reset holds everything at zero even with live inputs
      ex_bus  = mk_ex(32'hAAAA_0000, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd1, 32'h10, 32'h0);
      lohi_in = 65'h1_FFFF_0000_FFFF_0000;
      tick();
      tick();
      check_eq("rst_outs", {bus_if.data_req, stallreq, wb_bus, id_bus, lohi_out}, '0);
      check_eq("rst_state", dut.state_q, ST_IDLE);
      ex_bus  = '0;
      lohi_in = '0;
      rst     = 1'b1;
      tick();

      // LW 0x100, accepted and answered in the first request cycle
      ex_bus = mk_ex(32'h1000, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd5, 32'h100, 32'h0);
      tick();
      check_eq("lw_req", {bus_if.data_req, stallreq, bus_if.data_wr}, 3'b110);
      check_eq("lw_addr", {bus_if.data_addr, bus_if.data_size}, {32'h100, 2'd2});
      ex_bus = '0;
      stall  = STALL_HOLD;
      respond(1'b1, 1'b1, 32'hDEAD_BEEF);
      tick();
      respond(1'b0, 1'b0, 32'h0BAD_F00D);
      check_eq("lw_done", {bus_if.data_req, stallreq}, 2'b00);
      check_eq("lw_wb", wb_bus, {32'h1000, 1'b1, 5'd5, 32'hDEAD_BEEF});
      // Held stall in DONE must not reissue
      tick();
      tick();
      check_eq("lw_hold_req", bus_if.data_req, 1'b0);
      check_eq("lw_hold_state", dut.state_q, ST_DONE);
      check_eq("lw_hold_wb", wb_bus, {32'h1000, 1'b1, 5'd5, 32'hDEAD_BEEF});
      ex_bus = mk_ex(32'h1004, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd3, 32'h55, 32'h0);
      stall  = STALL_RUN;
      tick();
      check_eq("nop_state", dut.state_q, ST_IDLE);
      check_eq("nop_wb", {wb_bus, stallreq, bus_if.data_req},
               {32'h1004, 1'b1, 5'd3, 32'h55, 1'b0, 1'b0});

      // LB signed 0x103, data three cycles after accept
      ex_bus = mk_ex(32'h2000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd7, 32'h103, 32'h0);
      tick();
      check_eq("lb_st_req", dut.state_q, ST_REQ);
      ex_bus = '0;
      stall  = STALL_HOLD;
      respond(1'b1, 1'b0, 32'h0BAD_F00D);
      tick();
      respond(1'b0, 1'b0, 32'h0BAD_F00D);
      check_eq("lb_wait1", {dut.state_q, bus_if.data_req, stallreq}, {ST_WAIT, 2'b01});
      tick();
      check_eq("lb_wait2", {dut.state_q, bus_if.data_req, stallreq}, {ST_WAIT, 2'b01});
      tick();
      check_eq("lb_wait3", {dut.state_q, bus_if.data_req, stallreq}, {ST_WAIT, 2'b01});
      respond(1'b0, 1'b1, 32'h80FF_FF7F);
      tick();
      respond(1'b0, 1'b0, 32'h0BAD_F00D);
      check_eq("lb_done", {dut.state_q, stallreq}, {ST_DONE, 1'b0});
      check_eq("lb_id", id_bus, {1'b1, 5'd7, 32'hFFFF_FF80});
      // New memory op loads straight out of DONE
      ex_bus = mk_ex(32'h2004, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd8, 32'h300, 32'h0);
      stall  = STALL_RUN;
      tick();
      check_eq("done_to_req", {dut.state_q, bus_if.data_req}, {ST_REQ, 1'b1});
      ex_bus = '0;
      stall  = STALL_HOLD;
      respond(1'b1, 1'b1, 32'h0000_0001);
      tick();
      respond(1'b0, 1'b0, 32'h0BAD_F00D);
      stall = STALL_RUN;
      tick();

      // Load extraction variants
      do_load("lbu", 32'h101, 2'd0, 1'b0, 32'h0000_F200, 32'h0000_00F2);
      do_load("lb_pos", 32'h100, 2'd0, 1'b1, 32'h0000_007F, 32'h0000_007F);
      do_load("lh", 32'h104, 2'd1, 1'b1, 32'h0000_8765, 32'hFFFF_8765);
      do_load("lhu", 32'h106, 2'd1, 1'b0, 32'h8001_1234, 32'h0000_8001);
      do_load("lw2", 32'h108, 2'd2, 1'b1, 32'h8765_4321, 32'h8765_4321);

      // Store replication
      do_store("sb", 2'd0, 32'h1234_5678, 32'h7878_7878);
      do_store("sh", 2'd1, 32'hABCD_1234, 32'h1234_1234);
      do_store("sw", 2'd2, 32'hCAFE_BABE, 32'hCAFE_BABE);

      // Bubble insertion
      ex_bus  = mk_ex(32'h3000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd2, 32'h99, 32'h0);
      lohi_in = 65'h1_2345_6789_ABCD_EF01;
      stall   = STALL_RUN;
      tick();
      check_eq("pre_bub_wb", wb_bus, {32'h3000, 1'b1, 5'd2, 32'h99});
      check_eq("pre_bub_lohi", lohi_out, 65'h1_2345_6789_ABCD_EF01);
      stall = STALL_BUBBLE;
      tick();
      check_eq("bub_wb", {wb_bus, stallreq}, '0);
      check_eq("bub_lohi", lohi_out, 65'h0);
      ex_bus  = '0;
      lohi_in = '0;
      stall   = STALL_RUN;
      tick();

      // Reset in WAIT, late response must be ignored
      ex_bus = mk_ex(32'h6000, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd6, 32'h200, 32'h0);
      tick();
      ex_bus = '0;
      stall  = STALL_HOLD;
      respond(1'b1, 1'b0, 32'h0BAD_F00D);
      tick();
      respond(1'b0, 1'b0, 32'h0BAD_F00D);
      check_eq("rw_wait", dut.state_q, ST_WAIT);
      rst = 1'b0;
      #1;
      check_eq("rw_async", {dut.state_q, bus_if.data_req, stallreq, wb_bus}, '0);
      tick();
      rst   = 1'b1;
      stall = STALL_RUN;
      respond(1'b0, 1'b1, 32'hCAFE_F00D);
      tick();
      respond(1'b0, 1'b0, 32'h0BAD_F00D);
      check_eq("rw_idle", {dut.state_q, bus_if.data_req}, {ST_IDLE, 1'b0});
      check_eq("rw_hold", dut.rdata_hold_q, 32'h0);
      tick();
      check_eq("rw_hold2", dut.rdata_hold_q, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
